// File: rtl/ch_sched.sv
// Eight-channel round-robin merger with one-entry holding buffers and a fx-bus register slave.
// Strobe to out_vld takes 2 cycles; out_data/out_ch hold while out_rdy is low, and a full buffer drops new samples.
module ch_sched #(
  parameter int NCH = 8,
  parameter int DW  = 16
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [5:0]        dev_id,
  input  logic [NCH-1:0]    sm_vld,
  input  logic [NCH*DW-1:0] sm_data,
  output logic [DW-1:0]     out_data,
  output logic [2:0]        out_ch,
  output logic              out_vld,
  input  logic              out_rdy,
  input  logic [21:0]       fx_waddr,
  input  logic              fx_wr,
  input  logic [7:0]        fx_data,
  input  logic [21:0]       fx_raddr,
  input  logic              fx_rd,
  output logic [7:0]        fx_q
);

  localparam int PW = 3;

  localparam logic [15:0] OFF_CH_EN = 16'h0000;
  localparam logic [15:0] OFF_OVF   = 16'h0001;
  localparam logic [15:0] OFF_DROP0 = 16'h0002;
  localparam logic [15:0] OFF_PEND  = 16'h000A;

  logic [NCH-1:0] r_full;
  logic [DW-1:0]  r_buf [NCH];
  logic [NCH-1:0] r_ch_en;
  logic [NCH-1:0] r_ovf;
  logic [7:0]     r_drop [NCH];
  logic [PW-1:0]  r_last;
  logic [DW-1:0]  r_out_data;
  logic [PW-1:0]  r_out_ch;
  logic           r_out_vld;
  logic [7:0]     r_fx_q;

  logic           w_wsel;
  logic           w_rsel;
  logic [15:0]    w_woff;
  logic [15:0]    w_roff;
  logic           w_wr_en;
  logic           w_wr_ovf;
  logic [NCH-1:0] w_wr_drop;
  logic           w_load;
  logic           w_req;
  logic [PW-1:0]  w_win;
  logic [PW-1:0]  w_cand;
  logic [NCH-1:0] w_gnt;
  logic [NCH-1:0] w_acc;
  logic [NCH-1:0] w_cap;
  logic [NCH-1:0] w_drop;
  logic [NCH-1:0] w_full_nxt;
  logic [7:0]     w_rdata;

  assign out_data = r_out_data;
  assign out_ch   = r_out_ch;
  assign out_vld  = r_out_vld;
  assign fx_q     = r_fx_q;

  assign w_wsel   = fx_wr && (fx_waddr[21:16] == dev_id);
  assign w_rsel   = fx_rd && (fx_raddr[21:16] == dev_id);
  assign w_woff   = fx_waddr[15:0];
  assign w_roff   = fx_raddr[15:0];
  assign w_wr_en  = w_wsel && (w_woff == OFF_CH_EN);
  assign w_wr_ovf = w_wsel && (w_woff == OFF_OVF);

  always_comb begin
    w_wr_drop = '0;
    for (int i = 0; i < NCH; i++) begin
      w_wr_drop[i] = w_wsel && (w_woff == 16'(OFF_DROP0 + 16'(i)));
    end
  end

  // Search starts one past the last winner so every pending channel is served within NCH grants.
  always_comb begin
    w_req  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_cand = r_last + PW'(k);
      if (!w_req && r_full[w_cand]) begin
        w_req = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_load = !r_out_vld || out_rdy;
  assign w_gnt  = (w_req && w_load) ? (NCH'(1) << w_win) : '0;

  // A buffer being drained this cycle can take a new sample; otherwise a second sample is a drop.
  always_comb begin
    w_acc      = '0;
    w_cap      = '0;
    w_drop     = '0;
    w_full_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      w_acc[i]      = sm_vld[i] && r_ch_en[i];
      w_cap[i]      = w_acc[i] && (!r_full[i] || w_gnt[i]);
      w_drop[i]     = w_acc[i] && r_full[i] && !w_gnt[i];
      w_full_nxt[i] = w_cap[i] || (r_full[i] && !w_gnt[i]);
      if (w_wr_en && !fx_data[i]) begin
        w_full_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_roff)
      OFF_CH_EN: w_rdata = r_ch_en;
      OFF_OVF:   w_rdata = r_ovf;
      OFF_PEND:  w_rdata = r_full;
      default: begin
        for (int i = 0; i < NCH; i++) begin
          if (w_roff == 16'(OFF_DROP0 + 16'(i))) begin
            w_rdata = r_drop[i];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_full     <= '0;
      r_ch_en    <= '1;
      r_ovf      <= '0;
      r_last     <= '1;
      r_out_data <= '0;
      r_out_ch   <= '0;
      r_out_vld  <= 1'b0;
      r_fx_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_buf[i]  <= '0;
        r_drop[i] <= '0;
      end
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_en) begin
        r_ch_en <= fx_data;
      end
      // Drop sets after the W1C mask so a same-cycle drop survives the clear.
      r_ovf <= (r_ovf & ~(w_wr_ovf ? fx_data : 8'h00)) | w_drop;
      for (int i = 0; i < NCH; i++) begin
        if (w_cap[i]) begin
          r_buf[i] <= sm_data[i*DW +: DW];
        end
        if (w_drop[i]) begin
          if (w_wr_drop[i]) begin
            r_drop[i] <= 8'd1;
          end else if (r_drop[i] != 8'hFF) begin
            r_drop[i] <= r_drop[i] + 8'd1;
          end
        end else if (w_wr_drop[i]) begin
          r_drop[i] <= '0;
        end
      end
      if (w_req && w_load) begin
        r_out_data <= r_buf[w_win];
        r_out_ch   <= w_win;
        r_out_vld  <= 1'b1;
        r_last     <= w_win;
      end else if (out_rdy) begin
        r_out_vld  <= 1'b0;
      end
      r_fx_q <= w_rsel ? w_rdata : 8'h00;
    end
  end

endmodule

// File: tb/tb_ch_sched.sv
// Bench for ch_sched: output transfers are checked against a scoreboard queue, registers via fx-bus reads.
module tb_ch_sched;

  localparam logic [5:0] DEV = 6'h2A;

  logic         clk_sys = 1'b0;
  logic         rst;
  logic [5:0]   dev_id;
  logic [7:0]   sm_vld;
  logic [127:0] sm_data;
  logic [15:0]  out_data;
  logic [2:0]   out_ch;
  logic         out_vld;
  logic         out_rdy;
  logic [21:0]  fx_waddr;
  logic         fx_wr;
  logic [7:0]   fx_data;
  logic [21:0]  fx_raddr;
  logic         fx_rd;
  logic [7:0]   fx_q;

  int n_chk  = 0;
  int n_pass = 0;
  logic [18:0] sb_q [$];
  logic [18:0] sb_e;

  ch_sched #(.NCH(8), .DW(16)) dut (
    .clk_sys(clk_sys), .rst(rst), .dev_id(dev_id),
    .sm_vld(sm_vld), .sm_data(sm_data),
    .out_data(out_data), .out_ch(out_ch), .out_vld(out_vld), .out_rdy(out_rdy),
    .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
    .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [7:0] m, input logic [15:0] base);
    sm_vld = m;
    for (int i = 0; i < 8; i++) sm_data[i*16 +: 16] = base + 16'(i);
  endtask

  task automatic wr(input logic [15:0] off, input logic [7:0] d);
    fx_waddr = {DEV, off};
    fx_data  = d;
    fx_wr    = 1'b1;
    tick();
    fx_wr    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] off, input logic [7:0] exp, input string tag);
    fx_raddr = {DEV, off};
    fx_rd    = 1'b1;
    tick();
    fx_rd    = 1'b0;
    chk(tag, fx_q, exp);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    out_rdy = 1'b0;
    sm_vld  = '0;
    tick();
    rst     = 1'b0;
    sb_q.delete();
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected {ch, data}.
  always @(negedge clk_sys) begin
    if (!rst && out_vld && out_rdy) begin
      if (sb_q.size() == 0) chk("sb_extra_vld", out_vld, 0);
      else begin
        sb_e = sb_q.pop_front();
        chk("sb_ch", out_ch, sb_e[18:16]);
        chk("sb_data", out_data, sb_e[15:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; dev_id = DEV; sm_vld = '0; sm_data = '0; out_rdy = 1'b0;
    fx_waddr = '0; fx_wr = 1'b0; fx_data = '0; fx_raddr = '0; fx_rd = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state and address decode
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_fx_q", fx_q, 0);
    rd(16'h0000, 8'hFF, "rst_ch_en");
    chk("fx_q_idle", fx_q, 8'hFF);
    tick();
    chk("fx_q_cleared", fx_q, 0);
    rd(16'h0001, 8'h00, "rst_ovf");
    rd(16'h000A, 8'h00, "rst_pend");
    rd(16'h0005, 8'h00, "rst_drop3");
    rd(16'h0040, 8'h00, "unmapped");
    fx_raddr = {6'h15, 16'h0000}; fx_rd = 1'b1; tick(); fx_rd = 1'b0;
    chk("other_dev_rd", fx_q, 0);
    fx_waddr = {6'h15, 16'h0000}; fx_data = 8'h00; fx_wr = 1'b1; tick(); fx_wr = 1'b0;
    rd(16'h0000, 8'hFF, "other_dev_wr");

    // Single strobe: visible exactly two edges after the strobe, for one cycle
    do_reset();
    out_rdy = 1'b1;
    strobe(8'h08, 16'h0000);
    sm_data[3*16 +: 16] = 16'h1234;
    sb_q.push_back({3'd3, 16'h1234});
    tick();
    sm_vld = '0;
    chk("t1_vld_early", out_vld, 0);
    tick();
    chk("t1_vld", out_vld, 1);
    chk("t1_ch", out_ch, 3);
    chk("t1_data", out_data, 16'h1234);
    tick();
    chk("t1_vld_drop", out_vld, 0);

    // All eight at once: one transfer per cycle in channel order
    do_reset();
    out_rdy = 1'b1;
    strobe(8'hFF, 16'hA000);
    for (int i = 0; i < 8; i++) sb_q.push_back({3'(i), 16'hA000 + 16'(i)});
    tick();
    sm_vld = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t2_vld", out_vld, 1);
      chk("t2_ch", out_ch, k);
    end
    tick();
    chk("t2_idle", out_vld, 0);
    rd(16'h0001, 8'h00, "t2_ovf");

    // Backpressure on ch5: data 1 held, 2 buffered, 3 and 4 dropped
    do_reset();
    for (int d = 1; d <= 4; d++) begin
      strobe(8'h20, 16'h0000);
      sm_data[5*16 +: 16] = 16'(d);
      tick();
    end
    sm_vld = '0;
    sb_q.push_back({3'd5, 16'd1});
    sb_q.push_back({3'd5, 16'd2});
    chk("t3_vld", out_vld, 1);
    chk("t3_hold", out_data, 16'd1);
    rd(16'h0001, 8'h20, "t3_ovf");
    rd(16'h0007, 8'h02, "t3_drop5");
    rd(16'h000A, 8'h20, "t3_pend");
    chk("t3_stable", out_data, 16'd1);
    out_rdy = 1'b1;
    repeat (4) tick();
    chk("t3_drained", out_vld, 0);

    // Drop counter saturation, clears, and set-wins-over-clear
    do_reset();
    for (int n = 0; n < 302; n++) begin
      strobe(8'h01, 16'(n));
      tick();
    end
    sm_vld = '0;
    sb_q.push_back({3'd0, 16'd0});
    sb_q.push_back({3'd0, 16'd1});
    rd(16'h0002, 8'hFF, "t4_sat");
    rd(16'h0001, 8'h01, "t4_ovf");
    wr(16'h0002, 8'h00);
    rd(16'h0002, 8'h00, "t4_cnt_clr");
    wr(16'h0001, 8'h01);
    rd(16'h0001, 8'h00, "t4_ovf_w1c");
    fx_waddr = {DEV, 16'h0001}; fx_data = 8'h01; fx_wr = 1'b1;
    strobe(8'h01, 16'h0F0F);
    tick();
    fx_wr = 1'b0; sm_vld = '0;
    rd(16'h0001, 8'h01, "t4_ovf_set_wins");
    rd(16'h0002, 8'h01, "t4_cnt_one");
    fx_waddr = {DEV, 16'h0002}; fx_data = 8'h00; fx_wr = 1'b1;
    strobe(8'h01, 16'h0F0F);
    tick();
    fx_wr = 1'b0; sm_vld = '0;
    rd(16'h0002, 8'h01, "t4_inc_wins");
    out_rdy = 1'b1;
    repeat (4) tick();
    chk("t4_drained", out_vld, 0);

    // Disabled channel 0 never reaches the output
    do_reset();
    out_rdy = 1'b1;
    wr(16'h0000, 8'hFE);
    rd(16'h0000, 8'hFE, "t5_ch_en");
    strobe(8'hFF, 16'hB000);
    for (int i = 1; i < 8; i++) sb_q.push_back({3'(i), 16'hB000 + 16'(i)});
    tick();
    sm_vld = '0;
    rd(16'h000A, 8'hFE, "t5_pend");
    repeat (10) tick();
    rd(16'h0001, 8'h00, "t5_ovf");

    // Disabling a channel on the output lets it complete but flushes its buffer
    do_reset();
    strobe(8'h04, 16'h0000); sm_data[2*16 +: 16] = 16'h5A5A; tick();
    strobe(8'h04, 16'h0000); sm_data[2*16 +: 16] = 16'hA5A5; tick();
    sm_vld = '0;
    sb_q.push_back({3'd2, 16'h5A5A});
    wr(16'h0000, 8'hFB);
    rd(16'h000A, 8'h00, "t7_pend");
    chk("t7_vld", out_vld, 1);
    chk("t7_ch", out_ch, 2);
    out_rdy = 1'b1;
    repeat (3) tick();
    chk("t7_done", out_vld, 0);

    // Reset mid-operation discards output and pending buffers
    do_reset();
    wr(16'h0000, 8'h7F);
    strobe(8'hFF, 16'hC000);
    tick();
    sm_vld = '0;
    tick();
    chk("t6_pre_vld", out_vld, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_vld", out_vld, 0);
    chk("t6_data", out_data, 0);
    rd(16'h000A, 8'h00, "t6_pend");
    rd(16'h0000, 8'hFF, "t6_ch_en");

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ch_sched.md
# ch_sched

Round-robin scheduler that merges the eight smoothed channel streams (`sm_data`/`sm_vld` from the per-channel DSP blocks) into one tagged 16-bit stream for a single downstream consumer (storage/uplink path). Each channel has a one-entry holding buffer. A round-robin arbiter drains the buffers into a registered output stage with a valid/ready handshake. Channel enables, sticky overflow flags and per-channel drop counters are exposed as an fx-bus slave.

## Interface
Parameters:
- `NCH`, 8, number of channels; fixed at 8 for this design, pointer width is 3.
- `DW`, 16, sample width.

Ports:
- `clk_sys` in 1: system clock. Everything is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `dev_id` in 6: fx-bus device ID.
- `sm_vld` in 8: per-channel sample strobe, one-cycle pulse; bit i belongs to channel i.
- `sm_data` in 128: channel i sample is on bits [16i+15:16i].
- `out_data` out 16: sample being presented.
- `out_ch` out 3: source channel of `out_data`.
- `out_vld` out 1: output holds a sample.
- `out_rdy` in 1: consumer accepts; a transfer happens on a cycle where `out_vld` and `out_rdy` are both 1.
- `fx_waddr` in 22, `fx_wr` in 1, `fx_data` in 8: fx-bus write.
- `fx_raddr` in 22, `fx_rd` in 1: fx-bus read request.
- `fx_q` out 8: fx-bus read data.

## Operation
Address decode:
- The block is selected when addr[21:16] == `dev_id`. The register offset is addr[15:0].
- Reads to unselected or unmapped addresses return 0, because the fx bus ORs slave outputs.

Registers:
- 0x0000 `ch_en` RW, reset 0xFF. Writing bit i = 0 disables channel i and clears its buffer's full flag on the next edge.
- 0x0001 `ovf` R/W1C, reset 0x00. Bit i is set when a channel-i sample is dropped. Writing 1 to a bit clears it; a set from a drop in the same cycle wins over the clear.
- 0x0002–0x0009 `drop_cnt[0..7]` R, reset 0. 8-bit saturating count (stops at 255). Any write to the offset clears it; an increment in the same cycle wins, so the counter reads 1.
- 0x000A `pend` R. Current buffer full flags, bit i = channel i.

Holding buffers (per channel i):
- On `sm_vld[i]` with `ch_en[i]` = 0: ignore the sample.
- On `sm_vld[i]` with the buffer empty, or full but granted this cycle: capture the sample and set full.
- On `sm_vld[i]` with the buffer full and not granted this cycle: drop the new sample and keep the old one. Set `ovf[i]` and increment `drop_cnt[i]`.
- When granted and not refilled in the same cycle: clear full.

Arbiter:
- Combinational search over the full flags, starting at `last+1` and wrapping mod 8.
- A grant is issued only when the output stage can load (`!out_vld || out_rdy`).
- On a grant: load `out_data`/`out_ch` from the winner, set `out_vld`, and set `last` to the winner.
- When `out_rdy` is high with no request pending: clear `out_vld`.

## Timing
Reset values:
- `out_vld` = 0, `out_data` = 0, `out_ch` = 0, `fx_q` = 0.
- `last` = 7, so channel 0 has first priority.
- All buffers empty, `ch_en` = 0xFF, `ovf` = 0, all `drop_cnt` = 0.

Latency and handshake:
- A `sm_vld` pulse at edge t sets the buffer full at t. `out_vld` rises at edge t+1 if the output is free and the channel wins. Minimum latency is 2 cycles from the strobe to `out_vld` observed.
- `out_data`/`out_ch` stay stable while `out_vld` = 1 and `out_rdy` = 0.
- With `out_rdy` held at 1, the block sustains one transfer per cycle.
- No channel waits more than 8 grants once it is pending.

fx bus:
- Read: `fx_q` is registered and valid the cycle after `fx_rd`. It is 0 on all other cycles.
- Write: takes effect on the edge where `fx_wr` = 1.

Reset and boundary cases:
- `rst` asserted mid-operation: all state returns to reset values on that edge. A pending output is discarded.
- Disabling a channel while it is presented on the output: the registered output still completes.

## Test plan
- Reset, then single `sm_vld[3]` with data 0x1234 and `out_rdy` = 1 → `out_vld` = 1 with `out_ch` = 3 and `out_data` = 0x1234 two cycles after the strobe, for exactly one cycle.
- All 8 strobes in the same cycle, `out_rdy` = 1 → outputs in order ch0, ch1, …, ch7 on consecutive cycles. No drops, `ovf` = 0.
- Hold `out_rdy` = 0, pulse `sm_vld[5]` 4 times with data 1, 2, 3, 4 → the output holds data 1. `ovf` reads 0x20. `drop_cnt[5]` at 0x0007 reads 2: data 2 goes to the buffer, data 3 and 4 are dropped.
- `drop_cnt[0]` driven with 300 drops → reads 255. Write 0x0002 → reads 0. Write 0x01 to 0x0001 in the same cycle as a new ch0 drop → `ovf[0]` = 1 and `drop_cnt[0]` = 1.
- Write `ch_en` = 0xFE, pulse all 8 strobes → ch0 never appears on the output, and `pend[0]` = 0.
- Assert `rst` while `out_vld` = 1 and buffers are pending → on the next cycle `out_vld` = 0, `pend` = 0, and `ch_en` reads 0xFF one cycle after `fx_rd` to 0x0000.
